// File: rtl/clkmon_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package clkmon_pkg;

   // Defaults shared with the divider bench: 8-bit counters, 5 high / 5 low.
   localparam int unsigned CLKMON_CW       = 8;
   localparam int unsigned CLKMON_EXP_HIGH = 5;
   localparam int unsigned CLKMON_EXP_LOW  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Absolute difference of two unsigned values without wrap-around.
   function automatic int unsigned abs_diff(int unsigned a, int unsigned b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector for a signal already synchronous to clk.
module edge_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic in_q;

   // Previous sample; reset value chosen so a level held across reset is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q <= RST_VAL;
      end else begin
         in_q <= d;
      end
   end

   assign rise = d & ~in_q;
   assign fall = ~d & in_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures high/low/period of a divided clock sampled in the CLKin domain and
// tracks lock, sticky error and no-edge timeout.
module clk_period_monitor
   import clkmon_pkg::*;
#(
   parameter int unsigned CW       = CLKMON_CW,
   parameter int unsigned EXP_HIGH = CLKMON_EXP_HIGH,
   parameter int unsigned EXP_LOW  = CLKMON_EXP_LOW,
   parameter int unsigned TOL      = 0,
   parameter int unsigned LOCK_N   = 2
) (
   input  logic          CLKin,
   input  logic          RST,
   input  logic          CLKdiv,
   input  logic          err_clr,
   output logic [CW-1:0] high_cnt,
   output logic [CW-1:0] low_cnt,
   output logic [CW:0]   period,
   output logic          valid,
   output logic          locked,
   output logic          timeout,
   output logic          err
);

   localparam int unsigned MRW = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;
   localparam logic [MRW-1:0] MR_LOCK = MRW'(LOCK_N);
   localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   hi_tmp;
   logic [MRW-1:0]  match_run;
   logic            rise;
   logic            fall;
   logic            match;
   logic [MRW-1:0]  mr_inc;

   edge_detect #(
      .RST_VAL (1'b1)
   ) u_edge (
      .clk  (CLKin),
      .rst  (RST),
      .d    (CLKdiv),
      .rise (rise),
      .fall (fall)
   );

   // Tolerance test on the period being closed, plus saturating lock-run increment.
   always_comb begin
      match  = (abs_diff(32'(hi_tmp), EXP_HIGH) <= TOL) &&
               (abs_diff(32'(cnt), EXP_LOW) <= TOL);
      mr_inc = (match_run == MR_LOCK) ? match_run : match_run + MRW'(1);
   end

   // Level-length counter, phase FSM, publish registers and status flags.
   always_ff @(posedge CLKin or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         hi_tmp    <= '0;
         match_run <= '0;
         high_cnt  <= '0;
         low_cnt   <= '0;
         period    <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
         err       <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         // Any error-setting assignment below overrides this clear.
         if (err_clr) begin
            err <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= HIGH;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            HIGH: begin
               if (fall) begin
                  state  <= LOW;
                  hi_tmp <= cnt;
                  cnt    <= CNT_ONE;
               end else if (cnt == CNT_MAX) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  timeout   <= 1'b1;
                  err       <= 1'b1;
                  locked    <= 1'b0;
                  match_run <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            LOW: begin
               if (rise) begin
                  state    <= HIGH;
                  cnt      <= CNT_ONE;
                  high_cnt <= hi_tmp;
                  low_cnt  <= cnt;
                  period   <= {1'b0, hi_tmp} + {1'b0, cnt};
                  valid    <= 1'b1;
                  if (match) begin
                     match_run <= mr_inc;
                     locked    <= (mr_inc == MR_LOCK);
                  end else begin
                     match_run <= '0;
                     locked    <= 1'b0;
                     if (locked) begin
                        err <= 1'b1;
                     end
                  end
               end else if (cnt == CNT_MAX) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  timeout   <= 1'b1;
                  err       <= 1'b1;
                  locked    <= 1'b0;
                  match_run <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench: phase-based waveform stimulus against a behavioural model.
module tb_clk_period_monitor;

   localparam int CW     = 8;
   localparam int EXP_H  = 5;
   localparam int EXP_L  = 5;
   localparam int TOL    = 0;
   localparam int LOCK_N = 2;
   localparam int TO_LEN = 1 << CW;  // samples of one level that trigger a timeout

   logic          CLKin = 1'b0;
   logic          RST;
   logic          CLKdiv;
   logic          err_clr;
   logic [CW-1:0] high_cnt;
   logic [CW-1:0] low_cnt;
   logic [CW:0]   period;
   logic          valid;
   logic          locked;
   logic          timeout;
   logic          err;

   int checks = 0;
   int errors = 0;

   // Model: measurement view of the waveform.
   bit m_prev;      // last sampled level
   int m_len;       // samples of the current level so far
   bit m_armed;     // a genuine rise has opened a measurement
   int m_hi;        // completed high length of the open period, 0 if none
   int m_run;       // consecutive in-tolerance periods
   bit m_valid, m_tout, m_locked, m_err;
   int m_high, m_low, m_per;

   clk_period_monitor #(
      .CW       (CW),
      .EXP_HIGH (EXP_H),
      .EXP_LOW  (EXP_L),
      .TOL      (TOL),
      .LOCK_N   (LOCK_N)
   ) dut (
      .CLKin    (CLKin),
      .RST      (RST),
      .CLKdiv   (CLKdiv),
      .err_clr  (err_clr),
      .high_cnt (high_cnt),
      .low_cnt  (low_cnt),
      .period   (period),
      .valid    (valid),
      .locked   (locked),
      .timeout  (timeout),
      .err      (err)
   );

   always #5 CLKin = ~CLKin;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic model_reset();
      m_prev = 1'b1; m_len = 0; m_armed = 1'b0; m_hi = 0; m_run = 0;
      m_valid = 1'b0; m_tout = 1'b0; m_locked = 1'b0; m_err = 1'b0;
      m_high = 0; m_low = 0; m_per = 0;
   endtask

   task automatic model_step(input bit lvl, input bit clr);
      bit edge_seen;
      bit set_err;
      bit ok;
      int closing;
      edge_seen = (lvl != m_prev);
      closing   = m_len;
      set_err   = 1'b0;
      m_valid   = 1'b0;
      m_tout    = 1'b0;
      m_len     = edge_seen ? 1 : m_len + 1;
      m_prev    = lvl;
      if (edge_seen && lvl) begin
         if (m_armed && m_hi > 0) begin
            m_valid = 1'b1;
            m_high  = m_hi;
            m_low   = closing;
            m_per   = m_hi + closing;
            ok = (iabs(m_hi - EXP_H) <= TOL) && (iabs(closing - EXP_L) <= TOL);
            if (ok) begin
               m_run    = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
               m_locked = (m_run == LOCK_N);
            end else begin
               if (m_locked) set_err = 1'b1;
               m_run    = 0;
               m_locked = 1'b0;
            end
         end
         m_armed = 1'b1;
         m_hi    = 0;
      end else if (edge_seen && !lvl) begin
         if (m_armed) m_hi = closing;
      end else if (m_armed && m_len == TO_LEN) begin
         m_tout   = 1'b1;
         set_err  = 1'b1;
         m_locked = 1'b0;
         m_run    = 0;
         m_armed  = 1'b0;
         m_hi     = 0;
      end
      if (clr) m_err = 1'b0;
      if (set_err) m_err = 1'b1;
   endtask

   task automatic compare_all();
      check_val("valid", valid, m_valid);
      check_val("timeout", timeout, m_tout);
      check_val("locked", locked, m_locked);
      check_val("err", err, m_err);
      check_val("high_cnt", high_cnt, m_high);
      check_val("low_cnt", low_cnt, m_low);
      check_val("period", period, m_per);
   endtask

   // Drive one level for len samples, pulsing err_clr on sample clr_at (-1: never).
   task automatic run_phase(input bit lvl, input int len, input int clr_at);
      for (int i = 0; i < len; i++) begin
         @(negedge CLKin);
         CLKdiv  = lvl;
         err_clr = (i == clr_at);
         @(posedge CLKin);
         model_step(lvl, i == clr_at);
         #1;
         compare_all();
      end
   endtask

   task automatic clean_periods(input int n);
      for (int k = 0; k < n; k++) begin
         run_phase(1'b1, EXP_H, -1);
         run_phase(1'b0, EXP_L, -1);
      end
   endtask

   // Asynchronous reset between clock edges; outputs must clear before any edge.
   task automatic do_reset(input bit lvl);
      @(negedge CLKin);
      err_clr = 1'b0;
      #2 RST = 1'b1;
      CLKdiv = lvl;
      model_reset();
      #1;
      compare_all();
      @(negedge CLKin);
      RST = 1'b0;
   endtask

   initial begin
      int lvl_r;
      int len;
      int clr;
      RST     = 1'b1;
      CLKdiv  = 1'b0;
      err_clr = 1'b0;
      model_reset();
      #3;
      compare_all();
      #7 RST = 1'b0;

      // Clean divider waveform: lock after two matching periods.
      run_phase(1'b0, 3, -1);
      clean_periods(4);
      run_phase(1'b1, EXP_H, -1);

      // Stretched high while locked, then re-lock with err sticky.
      run_phase(1'b0, EXP_L, -1);
      run_phase(1'b1, 7, -1);
      run_phase(1'b0, EXP_L, -1);
      clean_periods(3);

      // err_clr alone, then long low phase timing out with err_clr on the same sample.
      run_phase(1'b1, EXP_H, 2);
      run_phase(1'b0, 300, TO_LEN - 1);
      clean_periods(3);

      // Low phase of exactly TO_LEN-1 samples is still a legal measurement.
      run_phase(1'b1, EXP_H, 0);
      run_phase(1'b0, TO_LEN - 1, -1);
      clean_periods(2);

      // Reset three samples into a high phase; partial measurement discarded.
      run_phase(1'b1, 3, -1);
      do_reset(1'b1);
      run_phase(1'b1, 2, -1);
      run_phase(1'b0, EXP_L, -1);
      clean_periods(3);

      // CLKdiv high across reset release must not count as a rise.
      do_reset(1'b1);
      run_phase(1'b1, 4, -1);
      run_phase(1'b0, EXP_L, -1);
      clean_periods(3);

      // High-phase timeout.
      run_phase(1'b1, 260, -1);
      run_phase(1'b0, EXP_L, -1);
      clean_periods(2);

      // Randomized phases, mostly nominal, some off-nominal and near-timeout.
      lvl_r = 1;
      for (int p = 0; p < 240; p++) begin
         if ($urandom_range(0, 59) == 0) begin
            len = $urandom_range(TO_LEN - 4, TO_LEN + 4);
         end else if ($urandom_range(0, 9) < 7) begin
            len = lvl_r ? EXP_H : EXP_L;
         end else begin
            len = $urandom_range(1, 9);
         end
         clr = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len - 1) : -1;
         run_phase(lvl_r[0], len, clr);
         lvl_r = 1 - lvl_r;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
